// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch/decode widths, reset PC and the IF/ID bundle layout.
package pipeline_pkg;
    localparam int ADDR_W_DEF = 9;
    localparam int INSTR_W_DEF = 32;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;
    typedef struct packed {
        logic                   valid;
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } if_id_t;
endpackage

// File: rtl/fetch_skid_reg.sv
// fetch_skid_reg: one-entry capture/hold/release register holding the read in flight at a stall.
module fetch_skid_reg
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               cap,
    input  logic               rel,
    input  logic [ADDR_W-1:0]  in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (cap) begin
            valid <= 1'b1;
            pc    <= in_pc;
            instr <= in_instr;
        end else if (rel) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC generation, 1-cycle I-MEM read tracking and registered IF/ID with skid on stall.
// Optional FETCH_PERF_EN adds fetch/bubble performance counters.
module if_fetch_stage
    import pipeline_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_bubble_cnt
);
    logic [ADDR_W-1:0]  pc_q, f2_pc, skid_pc;
    logic               f2_valid, skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    assign imem_addr = pc_q;
    fetch_skid_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .cap      (stall_i && f2_valid),
        .rel      (!stall_i),
        .in_pc    (f2_pc),
        .in_instr (imem_rdata),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            f2_valid   <= 1'b0;
            f2_pc      <= '0;
            ifid_valid <= 1'b0;
            ifid_pc    <= '0;
            ifid_instr <= '0;
        end else if (redirect_i) begin
            pc_q       <= redirect_pc_i;
            f2_valid   <= 1'b0;
            ifid_valid <= 1'b0;
        end else if (stall_i) begin
            f2_valid <= 1'b0;
        end else begin
            // skid holds the older instruction, so it drains before the live read
            ifid_valid <= skid_valid || f2_valid;
            ifid_pc    <= skid_valid ? skid_pc : f2_pc;
            ifid_instr <= skid_valid ? skid_instr : imem_rdata;
            f2_valid   <= 1'b1;
            f2_pc      <= pc_q;
            pc_q       <= pc_q + ADDR_W'(1);
        end
    end
`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (!redirect_i && !stall_i && (skid_valid || f2_valid))
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (!stall_i && !ifid_valid)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`else
    assign perf_fetch_cnt  = 32'd0;
    assign perf_bubble_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: randomized stall/redirect stimulus checked against a stream-level fetch model.
module tb_if_fetch_stage;
    localparam int AW = 9;
    localparam int IW = 32;
    logic          clk = 1'b0, rst = 1'b1, stall = 1'b0, redir = 1'b0;
    logic [AW-1:0] rpc = '0, addr, addr2, pc_o, pc2;
    logic [IW-1:0] rdata = '0, rdata2 = '0, instr_o, instr2;
    logic          valid_o, valid2;
    logic [31:0]   pf, pb, pf2, pb2;
    logic [IW-1:0] mem [0:(1<<AW)-1];
    int checks = 0, failures = 0;

    // model: a redirect/reset restarts a sequential pc stream that needs two unstalled edges to fill
    logic          m_valid;
    logic [AW-1:0] m_pc, m_next;
    logic [IW-1:0] m_instr;
    int            m_need;
    logic [31:0]   m_fetch, m_bubble;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall), .redirect_i(redir), .redirect_pc_i(rpc),
        .imem_addr(addr), .imem_rdata(rdata), .ifid_valid(valid_o), .ifid_pc(pc_o),
        .ifid_instr(instr_o), .perf_fetch_cnt(pf), .perf_bubble_cnt(pb)
    );
    if_fetch_stage #(.RESET_PC(9'h1FE)) dut2 (
        .clk(clk), .rst(rst), .stall_i(1'b0), .redirect_i(1'b0), .redirect_pc_i(9'h000),
        .imem_addr(addr2), .imem_rdata(rdata2), .ifid_valid(valid2), .ifid_pc(pc2),
        .ifid_instr(instr2), .perf_fetch_cnt(pf2), .perf_bubble_cnt(pb2)
    );

    always @(posedge clk) begin
        rdata  <= mem[addr];
        rdata2 <= mem[addr2];
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0; m_pc <= '0; m_instr <= '0; m_next <= '0; m_need <= 2;
            m_fetch <= '0; m_bubble <= '0;
        end else begin
            if (!stall && !m_valid) m_bubble <= m_bubble + 1;
            if (redir) begin
                m_need <= 2; m_next <= rpc; m_valid <= 1'b0;
            end else if (!stall) begin
                if (m_need > 1) begin
                    m_need <= m_need - 1; m_valid <= 1'b0;
                end else begin
                    m_need <= 0; m_valid <= 1'b1; m_pc <= m_next; m_instr <= mem[m_next];
                    m_next <= m_next + 1'b1; m_fetch <= m_fetch + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_valid", 64'(valid_o), 64'(m_valid));
            if (m_valid) begin
                chk("model_pc", 64'(pc_o), 64'(m_pc));
                chk("model_instr", 64'(instr_o), 64'(m_instr));
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetch", 64'(pf), 64'(m_fetch));
            chk("perf_bubble", 64'(pb), 64'(m_bubble));
`else
            chk("perf_fetch_off", 64'(pf), 64'd0);
            chk("perf_bubble_off", 64'(pb), 64'd0);
`endif
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 + i;
        @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_pc", 64'(pc_o), 64'd0);
        chk("rst_instr", 64'(instr_o), 64'd0);
        chk("rst_perf", 64'(pf | pb), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("first_edge_valid", 64'(valid_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("start_valid", 64'(valid_o), 64'd1);
            chk("start_pc", 64'(pc_o), 64'(i));
            chk("start_instr", 64'(instr_o), 64'(32'hA000_0000 + i));
            chk("rpc_valid", 64'(valid2), 64'd1);
            chk("rpc_pc", 64'(pc2), 64'((9'h1FE + i) & 9'h1FF));
            chk("rpc_instr", 64'(instr2), 64'(32'hA000_0000 + ((9'h1FE + i) & 9'h1FF)));
        end
        repeat (2) @(negedge clk);
        chk("pre_stall_pc", 64'(pc_o), 64'h5);
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold_pc", 64'(pc_o), 64'h5);
            chk("stall_hold_valid", 64'(valid_o), 64'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("release_pc6", 64'(pc_o), 64'h6);
        @(negedge clk);
        chk("release_pc7", 64'(pc_o), 64'h7);
        rpc = 9'h040; redir = 1'b1;
        @(negedge clk);
        redir = 1'b0;
        chk("redir_bubble1", 64'(valid_o), 64'd0);
        @(negedge clk);
        chk("redir_bubble2", 64'(valid_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("redir_valid", 64'(valid_o), 64'd1);
            chk("redir_pc", 64'(pc_o), 64'(9'h040 + i));
        end
        stall = 1'b1;
        repeat (2) @(negedge clk);
        rpc = 9'h100; redir = 1'b1;
        @(negedge clk);
        redir = 1'b0; stall = 1'b0;
        begin
            int n = 0;
            while (!valid_o && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("flush_timeout", 64'(n < 10), 64'd1);
            chk("flush_target_pc", 64'(pc_o), 64'h100);
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                rst = 1'b1; stall = 1'b0; redir = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                stall = ($urandom_range(0, 99) < 30);
                redir = ($urandom_range(0, 99) < 5);
                rpc   = ($urandom_range(0, 3) == 0) ? addr : AW'($urandom);
            end
        end
        stall = 1'b0; redir = 1'b0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
